// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register map, bit positions, widths.
// Used by wb_timer, its bus interface and the optional prescaler.
package wb_timer_pkg;

    localparam int CNT_W   = 32;
    localparam int PRESC_W = 8;
    localparam int LANES   = CNT_W / 8;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_AUTO_CLR_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT   = 2;
    localparam int CTRL_PRESC_LSB    = 8;

    localparam int STAT_MATCH_BIT = 0;
    localparam int STAT_OVF_BIT   = 1;

    localparam logic [CNT_W-1:0] COMPARE_RST = '1;

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone B3 classic slave bus bundle for wb_timer (master drives, slave answers).
interface wb_timer_if;
    import wb_timer_pkg::*;

    logic [3:0]       wb_adr_i;
    logic [CNT_W-1:0] wb_dat_i;
    logic [3:0]       wb_sel_i;
    logic             wb_we_i;
    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic [CNT_W-1:0] wb_dat_o;
    logic             wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/wb_timer_prescaler.sv
// Tick divider: counts 0..reload and pulses tick on the reload value, i.e. every reload+1 cycles.
// Only instantiated when WB_TIMER_PRESCALER_EN is defined.
module wb_timer_prescaler
    import wb_timer_pkg::*;
#(
    parameter int W = PRESC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] reload,
    input  logic         restart,
    output logic         tick
);

    logic [W-1:0] cnt_reg;

    assign tick = en & (cnt_reg == reload);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone B3 timer/compare slave: 32-bit up-counter, MATCH/OVF flags, level irq on MATCH.
// Optional per-tick prescaler enabled by defining WB_TIMER_PRESCALER_EN.
module wb_timer
    import wb_timer_pkg::*;
(
    input  logic      wb_clk_i,
    input  logic      wb_rst_i,
    wb_timer_if.slave wb,
    output logic      irq_o
);

    logic               ack_reg;
    logic [CNT_W-1:0]   dat_o_reg;
    logic               en_reg;
    logic               auto_clr_reg;
    logic               irq_en_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   compare_reg;
    logic               match_reg;
    logic               ovf_reg;
    logic [PRESC_W-1:0] prescale_val;

    logic             req;
    logic             wr_commit;
    reg_sel_e         reg_sel;
    logic             wr_ctrl, wr_count, wr_compare, wr_status;
    logic [CNT_W-1:0] count_merge, compare_merge;
    logic             tick;
    logic             count_adv, count_hit;
    logic [CNT_W-1:0] count_next;
    logic             match_set, ovf_set, match_clr, ovf_clr;
    logic [CNT_W-1:0] ctrl_rd, status_rd, rd_data;
    logic             unused_adr;

    assign req        = wb.wb_cyc_i & wb.wb_stb_i;
    // A write lands only if the master is still requesting when the ack goes out.
    assign wr_commit  = ack_reg & req & wb.wb_we_i;
    assign reg_sel    = reg_sel_e'(wb.wb_adr_i[3:2]);
    assign wr_ctrl    = wr_commit & (reg_sel == REG_CTRL);
    assign wr_count   = wr_commit & (reg_sel == REG_COUNT);
    assign wr_compare = wr_commit & (reg_sel == REG_COMPARE);
    assign wr_status  = wr_commit & (reg_sel == REG_STATUS);
    assign unused_adr = ^wb.wb_adr_i[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign count_merge[gi*8 +: 8]   = wb.wb_sel_i[gi] ? wb.wb_dat_i[gi*8 +: 8] : count_reg[gi*8 +: 8];
            assign compare_merge[gi*8 +: 8] = wb.wb_sel_i[gi] ? wb.wb_dat_i[gi*8 +: 8] : compare_reg[gi*8 +: 8];
        end
    endgenerate

`ifdef WB_TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] prescale_reg;
    logic               presc_restart;

    assign presc_restart = wr_count | (wr_ctrl & wb.wb_sel_i[1]);
    assign prescale_val  = prescale_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prescale_reg <= '0;
        end else if (wr_ctrl && wb.wb_sel_i[1]) begin
            prescale_reg <= wb.wb_dat_i[CTRL_PRESC_LSB +: PRESC_W];
        end
    end

    wb_timer_prescaler #(.W(PRESC_W)) u_prescaler (
        .clk     (wb_clk_i),
        .reset   (wb_rst_i),
        .en      (en_reg),
        .reload  (prescale_reg),
        .restart (presc_restart),
        .tick    (tick)
    );
`else
    assign prescale_val = '0;
    assign tick         = en_reg;
`endif

    // A bus write to COUNT pre-empts the tick entirely, including its flag side effects.
    assign count_adv  = tick & ~wr_count;
    assign count_hit  = (count_reg == compare_reg);
    assign count_next = (count_hit & auto_clr_reg) ? '0 : count_reg + CNT_W'(1);
    assign match_set  = count_adv & count_hit;
    assign ovf_set    = count_adv & (count_reg == '1) & ~(count_hit & auto_clr_reg);
    assign match_clr  = wr_status & wb.wb_sel_i[0] & wb.wb_dat_i[STAT_MATCH_BIT];
    assign ovf_clr    = wr_status & wb.wb_sel_i[0] & wb.wb_dat_i[STAT_OVF_BIT];

    always_comb begin
        ctrl_rd                                  = '0;
        ctrl_rd[CTRL_EN_BIT]                     = en_reg;
        ctrl_rd[CTRL_AUTO_CLR_BIT]               = auto_clr_reg;
        ctrl_rd[CTRL_IRQ_EN_BIT]                 = irq_en_reg;
        ctrl_rd[CTRL_PRESC_LSB +: PRESC_W]       = prescale_val;
        status_rd                                = '0;
        status_rd[STAT_MATCH_BIT]                = match_reg;
        status_rd[STAT_OVF_BIT]                  = ovf_reg;
        rd_data                                  = '0;
        case (reg_sel)
            REG_CTRL:    rd_data = ctrl_rd;
            REG_COUNT:   rd_data = count_reg;
            REG_COMPARE: rd_data = compare_reg;
            REG_STATUS:  rd_data = status_rd;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_reg      <= 1'b0;
            dat_o_reg    <= '0;
            en_reg       <= 1'b0;
            auto_clr_reg <= 1'b0;
            irq_en_reg   <= 1'b0;
            count_reg    <= '0;
            compare_reg  <= COMPARE_RST;
            match_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            ack_reg <= req & ~ack_reg;
            if (req && !ack_reg) begin
                dat_o_reg <= rd_data;
            end
            if (wr_ctrl && wb.wb_sel_i[0]) begin
                en_reg       <= wb.wb_dat_i[CTRL_EN_BIT];
                auto_clr_reg <= wb.wb_dat_i[CTRL_AUTO_CLR_BIT];
                irq_en_reg   <= wb.wb_dat_i[CTRL_IRQ_EN_BIT];
            end
            if (wr_compare) begin
                compare_reg <= compare_merge;
            end
            if (wr_count) begin
                count_reg <= count_merge;
            end else if (tick) begin
                count_reg <= count_next;
            end
            // Set beats a simultaneous write-1-to-clear.
            match_reg <= match_set | (match_reg & ~match_clr);
            ovf_reg   <= ovf_set | (ovf_reg & ~ovf_clr);
        end
    end

    assign wb.wb_ack_o = ack_reg;
    assign wb.wb_dat_o = dat_o_reg;
    assign irq_o       = irq_en_reg & match_reg;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: register table, directed corner sequences, random traffic vs model.
// Follows WB_TIMER_PRESCALER_EN the same way as the design.
module tb_wb_timer;
    import wb_timer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;

    wb_timer_if bus();

    wb_timer dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state, updated once per rising edge from the bench's own bus activity.
    bit          m_en, m_auto, m_irqen, m_match, m_ovf;
    logic [7:0]  m_presc, m_pcnt;
    logic [31:0] m_count, m_cmp;

    typedef struct {
        bit          we;
        logic [3:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] want;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_irqen = 0; m_match = 0; m_ovf = 0;
        m_presc = 8'h00; m_pcnt = 8'h00;
        m_count = 32'h0; m_cmp = 32'hFFFF_FFFF;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] adr);
        logic [7:0] p;
`ifdef WB_TIMER_PRESCALER_EN
        p = m_presc;
`else
        p = 8'h00;
`endif
        case (adr[3:2])
            2'd0:    return {16'h0, p, 5'h0, m_irqen, m_auto, m_en};
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return {30'h0, m_ovf, m_match};
        endcase
    endfunction

    task automatic model_step(input bit wr, input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bit          w_ctrl  = wr && (adr[3:2] == 2'd0);
        bit          w_count = wr && (adr[3:2] == 2'd1);
        bit          w_cmp   = wr && (adr[3:2] == 2'd2);
        bit          w_stat  = wr && (adr[3:2] == 2'd3);
        bit          tick;
        bit          set_m = 0;
        bit          set_o = 0;
        logic [32:0] inc;
`ifdef WB_TIMER_PRESCALER_EN
        tick = m_en && (m_pcnt == m_presc);
        if (w_count || (w_ctrl && sel[1])) m_pcnt = 8'h00;
        else if (m_en) m_pcnt = tick ? 8'h00 : m_pcnt + 8'h01;
`else
        tick = m_en;
`endif
        if (w_count) begin
            for (int b = 0; b < 4; b++) if (sel[b]) m_count[b*8 +: 8] = dat[b*8 +: 8];
        end else if (tick) begin
            if (m_count == m_cmp) set_m = 1;
            if (m_count == m_cmp && m_auto) begin
                m_count = 32'h0;
            end else begin
                inc     = {1'b0, m_count} + 33'd1;
                set_o   = inc[32];
                m_count = inc[31:0];
            end
        end
        if (w_ctrl && sel[0]) begin
            m_en = dat[0]; m_auto = dat[1]; m_irqen = dat[2];
        end
`ifdef WB_TIMER_PRESCALER_EN
        if (w_ctrl && sel[1]) m_presc = dat[15:8];
`endif
        if (w_cmp) begin
            for (int b = 0; b < 4; b++) if (sel[b]) m_cmp[b*8 +: 8] = dat[b*8 +: 8];
        end
        if (w_stat && sel[0]) begin
            if (dat[0]) m_match = 0;
            if (dat[1]) m_ovf = 0;
        end
        if (set_m) m_match = 1;
        if (set_o) m_ovf = 1;
    endtask

    // One clock: model follows the edge, DUT outputs are sampled on the falling edge.
    task automatic step(input bit wr, input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(wr, adr, dat, sel);
        @(negedge clk);
        check("irq", 32'(irq), 32'(m_irqen & m_match));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic drive(input bit we, input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr;  bus.wb_dat_i = dat;  bus.wb_sel_i = sel;
    endtask

    task automatic release_bus();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        drive(1'b1, adr, dat, sel);
        check("wr_ack_early", 32'(bus.wb_ack_o), 32'h0);
        step(1'b0, adr, dat, sel);
        check("wr_ack", 32'(bus.wb_ack_o), 32'h1);
        step(1'b1, adr, dat, sel);
        check("wr_ack_drop", 32'(bus.wb_ack_o), 32'h0);
        release_bus();
        $display("write adr=%h dat=%h sel=%b", adr, dat, sel);
    endtask

    task automatic bus_read(input logic [3:0] adr, output logic [31:0] data);
        logic [31:0] want;
        want = m_read(adr);
        drive(1'b0, adr, 32'h0, 4'hF);
        check("rd_ack_early", 32'(bus.wb_ack_o), 32'h0);
        step(1'b0, adr, 32'h0, 4'hF);
        check("rd_ack", 32'(bus.wb_ack_o), 32'h1);
        data = bus.wb_dat_o;
        check($sformatf("rd_model_%h", adr), data, want);
        step(1'b0, adr, 32'h0, 4'hF);
        check("rd_ack_drop", 32'(bus.wb_ack_o), 32'h0);
        release_bus();
        $display("read  adr=%h dat=%h", adr, data);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] v;
        logic [3:0]  a;
        logic [3:0]  s;
        int          kind;

        vecs[0]  = '{0, 4'h0, 32'h0,          4'hF,    32'h0000_0000};
        vecs[1]  = '{0, 4'h4, 32'h0,          4'hF,    32'h0000_0000};
        vecs[2]  = '{0, 4'h8, 32'h0,          4'hF,    32'hFFFF_FFFF};
        vecs[3]  = '{0, 4'hC, 32'h0,          4'hF,    32'h0000_0000};
        vecs[4]  = '{1, 4'h8, 32'h0000_AB00,  4'b0010, 32'h0};
        vecs[5]  = '{0, 4'h8, 32'h0,          4'hF,    32'hFFFF_ABFF};
        vecs[6]  = '{1, 4'h4, 32'h1234_5678,  4'b1001, 32'h0};
        vecs[7]  = '{0, 4'h4, 32'h0,          4'hF,    32'h1200_0078};
        vecs[8]  = '{1, 4'h0, 32'hFFFF_00FE,  4'hF,    32'h0};
        vecs[9]  = '{0, 4'h0, 32'h0,          4'hF,    32'h0000_0006};
        vecs[10] = '{1, 4'h1, 32'h0,          4'hF,    32'h0};
        vecs[11] = '{0, 4'h3, 32'h0,          4'hF,    32'h0000_0000};

        model_reset();
        release_bus();
        bus.wb_adr_i = 4'h0; bus.wb_dat_i = 32'h0; bus.wb_sel_i = 4'h0;

        // Reset state
        idle(3);
        check("rst_ack", 32'(bus.wb_ack_o), 32'h0);
        check("rst_dat", bus.wb_dat_o, 32'h0);
        rst = 1'b0;
        idle(1);

        // Register table: reset values, byte lanes, ignored address bits
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].adr, vecs[i].dat, vecs[i].sel);
            end else begin
                bus_read(vecs[i].adr, d);
                check($sformatf("vec%0d", i), d, vecs[i].want);
            end
        end

        // Compare match with auto-clear and irq, then W1C
        bus_write(4'h4, 32'h0, 4'hF);
        bus_write(4'h8, 32'd5, 4'hF);
        bus_write(4'h0, 32'h7, 4'hF);
        for (int k = 1; k <= 6; k++) begin
            idle(1);
            if (k == 5) check("irq_before_6th_tick", 32'(irq), 32'h0);
            if (k == 6) check("irq_on_6th_tick", 32'(irq), 32'h1);
        end
        bus_read(4'h4, d);
        bus_write(4'hC, 32'h1, 4'h1);
        check("irq_after_w1c", 32'(irq), 32'h0);
        bus_write(4'h0, 32'h0, 4'hF);
        bus_write(4'hC, 32'h3, 4'h1);

        // Overflow: exactly two ticks from FFFFFFFE
        bus_write(4'h4, 32'hFFFF_FFFE, 4'hF);
        bus_write(4'h0, 32'h1, 4'h1);
        bus_write(4'h0, 32'h0, 4'h1);
        bus_read(4'h4, d);
        check("ovf_count", d, 32'h0);
        bus_read(4'hC, d);
        check("ovf_status", d, 32'h2);
        check("ovf_no_irq", 32'(irq), 32'h0);
        bus_write(4'hC, 32'h3, 4'h1);

        // COUNT write on a tick cycle wins
        bus_write(4'h0, 32'h1, 4'h1);
        bus_write(4'h4, 32'h10, 4'hF);
        bus_read(4'h4, d);
        check("count_wr_on_tick", d, 32'h10);
        bus_write(4'h0, 32'h0, 4'h1);

        // MATCH set coincides with its W1C
        bus_write(4'h4, 32'h0, 4'hF);
        bus_write(4'h8, 32'd2, 4'hF);
        bus_write(4'h0, 32'h5, 4'h1);
        idle(1);
        bus_write(4'hC, 32'h1, 4'h1);
        check("set_beats_w1c_irq", 32'(irq), 32'h1);
        bus_write(4'h0, 32'h0, 4'h1);
        bus_read(4'hC, d);
        check("set_beats_w1c_status", 32'(d[0]), 32'h1);
        bus_write(4'hC, 32'h3, 4'h1);

        // Abandoned write: stb drops before ack
        drive(1'b1, 4'h8, 32'h5555_5555, 4'hF);
        step(1'b0, 4'h8, 32'h0, 4'hF);
        check("abandon_ack", 32'(bus.wb_ack_o), 32'h1);
        release_bus();
        step(1'b0, 4'h8, 32'h0, 4'hF);
        check("abandon_ack_drop", 32'(bus.wb_ack_o), 32'h0);
        bus_read(4'h8, d);
        check("abandon_compare", d, 32'd2);

        // Reset while a write is pending
        drive(1'b1, 4'h8, 32'h0000_1234, 4'hF);
        step(1'b0, 4'h8, 32'h0, 4'hF);
        rst = 1'b1;
        step(1'b0, 4'h8, 32'h0, 4'hF);
        check("rst_mid_ack", 32'(bus.wb_ack_o), 32'h0);
        rst = 1'b0;
        release_bus();
        idle(1);
        bus_read(4'h8, d);
        check("rst_mid_compare", d, 32'hFFFF_FFFF);

`ifdef WB_TIMER_PRESCALER_EN
        bus_write(4'h4, 32'h0, 4'hF);
        bus_write(4'h0, 32'h0000_0301, 4'b0011);
        idle(8);
        bus_read(4'h4, d);
        check("presc_count", d, 32'h2);
        bus_read(4'h0, d);
        check("presc_ctrl", d, 32'h0000_0301);
`else
        bus_write(4'h0, 32'h0000_0307, 4'b0011);
        bus_read(4'h0, d);
        check("ctrl_no_presc", d, 32'h0000_0007);
`endif
        bus_write(4'h0, 32'h0, 4'b0011);
        bus_write(4'hC, 32'h3, 4'h1);

        // Random traffic against the model
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 3));
            a    = 4'(kind * 4);
            s    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            if ($urandom_range(0, 2) == 0) begin
                bus_read(a, d);
            end else begin
                case (kind)
                    0:       v = {16'h0, 8'($urandom_range(0, 3)), 5'h0, 3'($urandom_range(0, 7))};
                    1: begin
                        case ($urandom_range(0, 2))
                            0:       v = m_cmp - 32'($urandom_range(0, 3));
                            1:       v = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                            default: v = $urandom;
                        endcase
                    end
                    2:       v = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
                    default: v = 32'($urandom_range(0, 3));
                endcase
                bus_write(a, v, s);
            end
            idle(int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
